lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Load/store initiator between the pipeline memory stage and the word-organised data memory.
- The memory offers only whole-word reads (combinational, gated by MemRead) and whole-word writes (on posedge when MemWrite is high).
- This block turns byte, halfword and word loads/stores into word accesses:
  - loads: lane extraction and sign/zero extension;
  - sub-word stores: read-modify-write;
  - misaligned, illegal or out-of-range requests: flagged as errors.
- Pipeline side uses a valid/ready request and a one-cycle response pulse.

Parameters:
- DEPTH, 512, number of 32-bit words in the target memory; byte address must satisfy addr[31:2] < DEPTH.
- AW, 32, pipeline byte-address width.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  pipeline request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V size/sign code.
- req_addr  in  AW  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result (0 for stores and errors).
- resp_err  out  1  valid with resp_valid: misaligned, illegal funct3, or out-of-range.
- MemRead  out  1  memory read enable.
- MemWrite  out  1  memory write enable.
- address  out  32  word index to memory = zero-extended addr[31:2].
- writeData  out  32  word written to memory.
- readData  in  32  word read from memory, combinational.

Behaviour:
- Reset, asynchronous, rst_n low:
  - state = IDLE;
  - request registers, captured word, resp_valid, resp_rdata, resp_err, MemRead, MemWrite, address, writeData all 0;
  - req_ready = 1 after rst_n deasserts.
- Reset mid-operation aborts the transaction. No partial write is issued after reset, and no response is produced.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch we, funct3, addr, wdata and classify:
    - err if funct3 illegal: loads allow 000, 001, 010, 100, 101; stores allow 000, 001, 010;
    - err if halfword with addr[0] = 1;
    - err if word with addr[1:0] != 0;
    - err if addr[31:2] >= DEPTH.
  - Next state:
    - err -> RESP with err = 1;
    - load -> RD;
    - SW -> WR;
    - SB/SH -> RD.
- RD:
  - MemRead = 1, address = word index.
  - Capture readData at posedge.
  - Next state: load -> RESP; sub-word store -> WR.
- WR:
  - MemWrite = 1, address = word index.
  - writeData:
    - SW: req_wdata;
    - SB: captured word with byte lane addr[1:0] replaced by wdata[7:0];
    - SH: captured word with lanes {addr[1],1}:{addr[1],0} replaced by wdata[15:0].
  - Next state: RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle, resp_err per classification, resp_rdata registered.
  - Load data:
    - LB/LBU: lane addr[1:0], sign- or zero-extended;
    - LH/LHU: halfword addr[1], extended;
    - LW: full word.
  - Next state: IDLE.
- Byte order: little-endian, byte 0 = bits [7:0].
- MemRead and MemWrite are never high in the same cycle. Both are 0 in IDLE and RESP.
- Latency from accept edge to resp_valid cycle:
  - load: 2 cycles;
  - SW: 2 cycles;
  - SB/SH: 3 cycles;
  - error: 1 cycle.
- Back-to-back issue: a new request is accepted only in IDLE, i.e. the cycle after RESP. Throughput is one request per 3 cycles (load/SW) or per 4 cycles (SB/SH).
- Requests arriving while req_ready = 0 are ignored; the pipeline holds them.
- Error requests never assert MemRead or MemWrite.

Decomposition:
- Package lsu_pkg:
  - state enum {IDLE, RD, WR, RESP};
  - funct3 constants F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101;
  - helper function is_legal(we, funct3).
- One combinational sub-module, lsu_lane_align, with two paths:
  - load extract/extend: word, addr[1:0], funct3 -> rdata;
  - store merge: old word, wdata, addr[1:0], funct3 -> new word.
- FSM and registers stay in lsu_mem_master.

Test Plan:
- Memory word 4 = 0x8899AABB.
  - LB addr 0x11 -> RD cycle with address = 4; resp 2 cycles after accept, rdata = 0xFFFFFFAA, err = 0.
  - LBU addr 0x11 -> rdata 0x000000AA.
- SB addr 0x12, wdata 0x000000CC, word 4 = 0x8899AABB -> RD then WR with writeData = 0x88CCAABB. Subsequent LW addr 0x10 -> rdata 0x88CCAABB. Response 3 cycles after accept.
- SW addr 0x20, wdata 0xDEADBEEF -> no MemRead; WR at address 8 with writeData 0xDEADBEEF; resp 2 cycles after accept.
- Errors: LH addr 0x13, LW addr 0x22, load funct3 = 3'b011, SW addr 0x800 (word 512 with DEPTH 512) -> each gives resp_valid one cycle after accept with err = 1, rdata = 0, and MemRead/MemWrite never asserted.
- Back-to-back traffic: req_valid held high with 4 queued loads -> req_ready high only in IDLE, 4 responses spaced 3 cycles apart, no request dropped or duplicated.
- Reset during an SH: rst_n pulled low during the RD cycle -> outputs 0 immediately, no MemWrite ever asserted, and after release the next LW returns the original unmodified word.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory master.
// Contents: FSM state enum, RISC-V funct3 size codes, request classification helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores have no unsigned variants; loads accept all five size codes.
    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        logic legal;
        if (we) begin
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        return legal;
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic mis;
        case (funct3)
            F3_H, F3_HU: mis = off[0];
            F3_W:        mis = (off != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Pipeline request/response channel plus word-memory port of the load/store master.
// master modport: the LSU itself; slave modport: the environment (pipeline + memory).
interface lsu_mem_master_if #(
    parameter int unsigned AW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          MemRead;
    logic          MemWrite;
    logic [31:0]   address;
    logic [31:0]   writeData;
    logic [31:0]   readData;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, readData,
        output req_ready, resp_valid, resp_rdata, resp_err,
               MemRead, MemWrite, address, writeData
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, readData,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               MemRead, MemWrite, address, writeData
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic for sub-word accesses (little-endian, byte 0 = [7:0]).
// Ports: word (memory word), wdata (right-aligned store data), off (addr[1:0]), funct3,
//        load_data_c (extracted + extended load), store_word_c (word with store lanes merged).
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data_c,
    output logic [31:0] store_word_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  lane_we;
    logic [31:0] wide;

    // Load path: pick the addressed lane and extend it.
    always_comb begin
        byte_sel    = word[{off, 3'b000} +: 8];
        half_sel    = word[{off[1], 4'b0000} +: 16];
        load_data_c = '0;
        case (funct3)
            F3_B:    load_data_c = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data_c = {24'h0, byte_sel};
            F3_H:    load_data_c = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data_c = {16'h0, half_sel};
            F3_W:    load_data_c = word;
            default: load_data_c = '0;
        endcase
    end

    // Store path: replicate store data across lanes, then overwrite only the enabled lanes.
    always_comb begin
        lane_we      = 4'b1111;
        wide         = wdata;
        store_word_c = '0;
        case (funct3)
            F3_B: begin
                lane_we = 4'b0001 << off;
                wide    = {4{wdata[7:0]}};
            end
            F3_H: begin
                lane_we = off[1] ? 4'b1100 : 4'b0011;
                wide    = {2{wdata[15:0]}};
            end
            default: begin
                lane_we = 4'b1111;
                wide    = wdata;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            store_word_c[8*i +: 8] = lane_we[i] ? wide[8*i +: 8] : word[8*i +: 8];
        end
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: turns byte/halfword/word requests into whole-word memory
// accesses (read-modify-write for sub-word stores) and flags bad requests.
// Ports: clk, rst_n (async active-low), bus (lsu_mem_master_if.master: pipeline
//        valid/ready request + one-cycle response, word memory read/write port).
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = 32
) (
    input logic              clk,
    input logic              rst_n,
    lsu_mem_master_if.master bus
);

    localparam int unsigned WIDX_W = AW - 2;

    state_t        state, state_n;

    logic          we_q;
    logic [2:0]    f3_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;

    logic          ready_q,      ready_n;
    logic          resp_valid_q, resp_valid_n;
    logic          resp_err_q,   resp_err_n;
    logic [31:0]   resp_rdata_q, resp_rdata_n;
    logic          mem_read_q,   mem_read_n;
    logic          mem_write_q,  mem_write_n;
    logic [31:0]   address_q,    address_n;
    logic [31:0]   write_data_q, write_data_n;

    logic          req_err_c;
    logic [31:0]   load_data_c;
    logic [31:0]   store_word_c;

    // Classify the request presented in IDLE.
    always_comb begin
        req_err_c = !is_legal(bus.req_we, bus.req_funct3) ||
                    is_misaligned(bus.req_funct3, bus.req_addr[1:0]) ||
                    (bus.req_addr[AW-1:2] >= WIDX_W'(DEPTH));
    end

    // Lane logic works on the live read word; it is only consumed while in RD.
    lsu_lane_align u_align (
        .word         (bus.readData),
        .wdata        (wdata_q),
        .off          (addr_q[1:0]),
        .funct3       (f3_q),
        .load_data_c  (load_data_c),
        .store_word_c (store_word_c)
    );

    // Next state plus the next value of every registered output, so each output
    // is already correct in the cycle its state is entered.
    always_comb begin
        state_n      = state;
        ready_n      = 1'b0;
        resp_valid_n = 1'b0;
        resp_err_n   = 1'b0;
        resp_rdata_n = '0;
        mem_read_n   = 1'b0;
        mem_write_n  = 1'b0;
        address_n    = '0;
        write_data_n = '0;
        case (state)
            IDLE: begin
                ready_n = 1'b1;
                if (bus.req_valid) begin
                    ready_n = 1'b0;
                    if (req_err_c) begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                    end else if (bus.req_we && (bus.req_funct3 == F3_W)) begin
                        // Full-word store needs no read.
                        state_n      = WR;
                        mem_write_n  = 1'b1;
                        address_n    = 32'(bus.req_addr[AW-1:2]);
                        write_data_n = bus.req_wdata;
                    end else begin
                        state_n    = RD;
                        mem_read_n = 1'b1;
                        address_n  = 32'(bus.req_addr[AW-1:2]);
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    state_n      = WR;
                    mem_write_n  = 1'b1;
                    address_n    = 32'(addr_q[AW-1:2]);
                    write_data_n = store_word_c;
                end else begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                    resp_rdata_n = load_data_c;
                end
            end
            WR: begin
                state_n      = RESP;
                resp_valid_n = 1'b1;
            end
            RESP: begin
                state_n = IDLE;
                ready_n = 1'b1;
            end
            default: begin
                state_n = IDLE;
                ready_n = 1'b1;
            end
        endcase
    end

    // State, request capture and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            f3_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
        end else begin
            state        <= state_n;
            ready_q      <= ready_n;
            resp_valid_q <= resp_valid_n;
            resp_err_q   <= resp_err_n;
            resp_rdata_q <= resp_rdata_n;
            mem_read_q   <= mem_read_n;
            mem_write_q  <= mem_write_n;
            address_q    <= address_n;
            write_data_q <= write_data_n;
            if ((state == IDLE) && bus.req_valid) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.MemRead    = mem_read_q;
    assign bus.MemWrite   = mem_write_q;
    assign bus.address    = address_q;
    assign bus.writeData  = write_data_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: word memory model, per-cycle expectation queue
// built from request semantics, directed cases and random traffic.
module tb_lsu_mem_master;

    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = 32;

    typedef struct {
        bit          ready;
        bit          rd;
        bit          wr;
        bit          rv;
        bit          rerr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_mem_master_if #(.AW(AW)) bus ();

    lsu_mem_master #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] dev_mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    exp_t        plan[$];

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          accept_cyc  = 0;
    int          last_resp_cyc = 0;
    int          n_reads = 0, n_writes = 0, n_resps = 0;
    logic [31:0] last_rdata = '0, last_wdata = '0, last_waddr = '0, last_raddr = '0;
    logic        last_err = 1'b0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h8899AABB;
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic exp_t blank_exp();
        exp_t e;
        e.ready = 1'b0; e.rd = 1'b0; e.wr = 1'b0; e.rv = 1'b0; e.rerr = 1'b0;
        e.addr = '0; e.wdata = '0; e.rdata = '0;
        return e;
    endfunction

    // Load result: shift the addressed byte down, then extend to 32 bits.
    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] off);
        logic [31:0] s;
        s = word >> (8 * int'(off));
        case (f3)
            3'b000:  return 32'($signed(s[7:0]));
            3'b100:  return {24'h0, s[7:0]};
            3'b001:  return 32'($signed(s[15:0]));
            3'b101:  return {16'h0, s[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [2:0] f3, input logic [1:0] off);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
        if (f3 == 3'b000) begin
            b[off] = wdata[7:0];
        end else if (f3 == 3'b001) begin
            b[off]      = wdata[7:0];
            b[off + 2'd1] = wdata[15:8];
        end else begin
            return wdata;
        end
        return {b[3], b[2], b[1], b[0]};
    endfunction

    // Expected per-cycle bus behaviour for one request, starting with the accept cycle.
    task automatic build_plan(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata);
        exp_t        e;
        logic [31:0] idx;
        int unsigned size;
        bit          legal, err;
        idx   = addr >> 2;
        size  = 1 << f3[1:0];
        legal = we ? (f3 inside {3'b000, 3'b001, 3'b010})
                   : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        err   = !legal || ((addr % size) != 0) || (idx >= DEPTH);
        e = blank_exp(); e.ready = 1'b1; plan.push_back(e);
        if (err) begin
            e = blank_exp(); e.rv = 1'b1; e.rerr = 1'b1; plan.push_back(e);
        end else if (!we) begin
            e = blank_exp(); e.rd = 1'b1; e.addr = idx; plan.push_back(e);
            e = blank_exp(); e.rv = 1'b1;
            e.rdata = model_load(ref_mem[idx[8:0]], f3, addr[1:0]); plan.push_back(e);
        end else begin
            if (f3 != 3'b010) begin
                e = blank_exp(); e.rd = 1'b1; e.addr = idx; plan.push_back(e);
            end
            e = blank_exp(); e.wr = 1'b1; e.addr = idx;
            e.wdata = model_store(ref_mem[idx[8:0]], wdata, f3, addr[1:0]); plan.push_back(e);
            e = blank_exp(); e.rv = 1'b1; plan.push_back(e);
        end
    endtask

    // Word memory: combinational gated read, posedge write.
    initial begin
        for (int i = 0; i < DEPTH; i++) dev_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (bus.MemWrite) dev_mem[bus.address[8:0]] <= bus.writeData;
        end
    end
    assign bus.readData = bus.MemRead ? dev_mem[bus.address[8:0]] : 32'h0;

    // Compare process: every cycle, DUT outputs against the expectation queue.
    initial begin
        exp_t e;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("rst_MemRead",    32'(bus.MemRead),    32'h0);
                chk("rst_MemWrite",   32'(bus.MemWrite),   32'h0);
                chk("rst_address",    bus.address,         32'h0);
                chk("rst_writeData",  bus.writeData,       32'h0);
                chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
                chk("rst_resp_err",   32'(bus.resp_err),   32'h0);
                chk("rst_resp_rdata", bus.resp_rdata,      32'h0);
                continue;
            end
            if (plan.size() > 0) begin
                e = plan.pop_front();
            end else begin
                e = blank_exp(); e.ready = 1'b1;
            end
            chk("req_ready",  32'(bus.req_ready),  32'(e.ready));
            chk("MemRead",    32'(bus.MemRead),    32'(e.rd));
            chk("MemWrite",   32'(bus.MemWrite),   32'(e.wr));
            chk("resp_valid", 32'(bus.resp_valid), 32'(e.rv));
            if (e.rd || e.wr) chk("address", bus.address, e.addr);
            if (e.wr) begin
                chk("writeData", bus.writeData, e.wdata);
                ref_mem[e.addr[8:0]] = e.wdata;
            end
            if (e.rv) begin
                chk("resp_err",   32'(bus.resp_err), 32'(e.rerr));
                chk("resp_rdata", bus.resp_rdata,    e.rdata);
            end
            if (bus.MemRead)  begin n_reads++;  last_raddr = bus.address; end
            if (bus.MemWrite) begin n_writes++; last_waddr = bus.address; last_wdata = bus.writeData; end
            if (bus.resp_valid) begin
                n_resps++;
                last_resp_cyc = cyc;
                last_rdata    = bus.resp_rdata;
                last_err      = bus.resp_err;
            end
        end
    end

    // Present a request (called at posedge+1) and hold it until accepted.
    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        int waited = 0;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        while (bus.req_ready !== 1'b1) begin
            if (waited > 20) begin
                chk("accept_timeout", 32'h0, 32'h1);
                bus.req_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            waited++;
        end
        accept_cyc = cyc + 1;
        build_plan(we, f3, addr, wdata);
        @(posedge clk); #1;
    endtask

    task automatic wait_done();
        int n = 0;
        bus.req_valid = 1'b0;
        while ((plan.size() != 0) && (n < 30)) begin
            @(posedge clk); #1;
            n++;
        end
        if (plan.size() != 0) chk("drain_timeout", 32'(plan.size()), 32'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          r0, w0, q0, first_acc;
        bit          we;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] idx;
        logic [31:0] addr;
        logic [2:0]  ef3   [4] = '{3'b001, 3'b010, 3'b011, 3'b010};
        logic [31:0] eaddr [4] = '{32'h13, 32'h22, 32'h10, 32'h800};
        bit          ewe   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("ready_after_reset", 32'(bus.req_ready), 32'h1);

        // LB / LBU on word 4 = 0x8899AABB
        issue(1'b0, 3'b000, 32'h11, 32'h0); wait_done();
        chk("lb_rdata", last_rdata, 32'hFFFFFFAA);
        chk("lb_raddr", last_raddr, 32'h4);
        chk("lb_latency", 32'(last_resp_cyc - accept_cyc), 32'd2);
        chk("lb_err", 32'(last_err), 32'h0);
        issue(1'b0, 3'b100, 32'h11, 32'h0); wait_done();
        chk("lbu_rdata", last_rdata, 32'h000000AA);

        // SB read-modify-write then readback
        r0 = n_reads; w0 = n_writes;
        issue(1'b1, 3'b000, 32'h12, 32'h000000CC); wait_done();
        chk("sb_writeData", last_wdata, 32'h88CCAABB);
        chk("sb_waddr", last_waddr, 32'h4);
        chk("sb_latency", 32'(last_resp_cyc - accept_cyc), 32'd3);
        chk("sb_reads", 32'(n_reads - r0), 32'd1);
        chk("sb_writes", 32'(n_writes - w0), 32'd1);
        issue(1'b0, 3'b010, 32'h10, 32'h0); wait_done();
        chk("lw_after_sb", last_rdata, 32'h88CCAABB);

        // SW: no read, direct write
        r0 = n_reads;
        issue(1'b1, 3'b010, 32'h20, 32'hDEADBEEF); wait_done();
        chk("sw_reads", 32'(n_reads - r0), 32'd0);
        chk("sw_waddr", last_waddr, 32'h8);
        chk("sw_writeData", last_wdata, 32'hDEADBEEF);
        chk("sw_latency", 32'(last_resp_cyc - accept_cyc), 32'd2);

        // Error requests
        for (int k = 0; k < 4; k++) begin
            r0 = n_reads; w0 = n_writes;
            issue(ewe[k], ef3[k], eaddr[k], 32'h12345678); wait_done();
            chk("err_latency", 32'(last_resp_cyc - accept_cyc), 32'd1);
            chk("err_flag", 32'(last_err), 32'h1);
            chk("err_rdata", last_rdata, 32'h0);
            chk("err_mem_access", 32'((n_reads - r0) + (n_writes - w0)), 32'd0);
        end

        // Back-to-back loads with req_valid held high
        q0 = n_resps;
        issue(1'b0, 3'b010, 32'h0, 32'h0);
        first_acc = accept_cyc;
        issue(1'b0, 3'b001, 32'h6, 32'h0);
        issue(1'b0, 3'b100, 32'h13, 32'h0);
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        wait_done();
        chk("b2b_resp_count", 32'(n_resps - q0), 32'd4);
        chk("b2b_span", 32'(last_resp_cyc - first_acc), 32'd11);

        // Reset during SH read cycle: no write, word unchanged
        w0 = n_writes; q0 = n_resps;
        issue(1'b1, 3'b001, 32'h52, 32'h00001234);
        chk("sh_in_rd", 32'(bus.MemRead), 32'h1);
        #2 rst_n = 1'b0;
        plan.delete();
        bus.req_valid = 1'b0;
        #1;
        chk("abort_MemRead",    32'(bus.MemRead),    32'h0);
        chk("abort_MemWrite",   32'(bus.MemWrite),   32'h0);
        chk("abort_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("abort_address",    bus.address,         32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        issue(1'b0, 3'b010, 32'h50, 32'h0); wait_done();
        chk("abort_no_write", 32'(n_writes - w0), 32'd0);
        chk("abort_one_resp", 32'(n_resps - q0), 32'd1);
        chk("abort_word_intact", last_rdata, init_word(20));

        // Random traffic
        for (int k = 0; k < 250; k++) begin
            we = 1'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                f3 = 3'($urandom);
            end else if (we) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 >= 3'd3) f3 = f3 + 3'd1;
            end
            off = 2'($urandom_range(0, 3));
            if ((f3[1:0] == 2'b01) && ($urandom_range(0, 3) != 0)) off[0] = 1'b0;
            if ((f3[1:0] == 2'b10) && ($urandom_range(0, 3) != 0)) off = 2'b00;
            if ($urandom_range(0, 15) == 0) idx = 32'(DEPTH) + 32'($urandom_range(0, 1000));
            else                            idx = 32'($urandom_range(0, DEPTH - 1));
            addr = {idx[29:0], off};
            issue(we, f3, addr, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                bus.req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        wait_done();
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
